// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 for the M stage of the P7 MIPS pipeline.
// Holds SR/Cause/EPC/PRId, decides combinationally whether the current
// M-stage instruction (or a pending hardware interrupt) diverts the pipeline
// to the handler, and services mtc0/mfc0/eret.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2018_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic        m_valid,
    input  logic [5:0]  hwint,
    input  logic        exl_clr,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        int_req
);

    // Architectural state
    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exccode_r;
    logic [31:0] epc_r;

    // Request / datapath helpers
    logic        int_pend_s;
    logic        exc_pend_s;
    logic        int_req_s;
    logic [31:0] pc_aligned_s;
    logic [31:0] exc_epc_s;
    logic [31:0] din_aligned_s;
    logic        wr_sr_s;
    logic        wr_epc_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;

    assign sr_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
    assign cause_s = {bd_r, 15'd0, ip_r, 3'd0, exccode_r, 2'd0};

    // Request decision plus the EPC values a take or an mtc0 would capture.
    always_comb begin
        int_pend_s    = (|(hwint & im_r)) & ie_r & ~exl_r & m_valid;
        exc_pend_s    = (exccode_m != 5'd0) & ~exl_r;
        // Reset silences the request so nothing downstream flushes mid-reset.
        int_req_s     = (int_pend_s | exc_pend_s) & ~reset;
        pc_aligned_s  = pc_m & 32'hFFFF_FFFC;
        din_aligned_s = din & 32'hFFFF_FFFC;
        // Delay-slot victims restart at the branch; wraps modulo 2^32.
        if (bd_m) begin
            exc_epc_s = pc_aligned_s - 32'd4;
        end else begin
            exc_epc_s = pc_aligned_s;
        end
        // A take discards any mtc0 in the same cycle.
        wr_sr_s  = we & (a2 == 5'd12) & ~int_req_s;
        wr_epc_s = we & (a2 == 5'd14) & ~int_req_s;
    end

    assign int_req = int_req_s;

    // Forward an in-flight mtc0 EPC so an eret in the same cycle sees it.
    always_comb begin
        epc_out = epc_r;
        if (wr_epc_s) begin
            epc_out = din_aligned_s;
        end else begin
            epc_out = epc_r;
        end
    end

    // mfc0 read mux over current register contents (no write-through).
    always_comb begin
        dout = 32'd0;
        case (a1)
            5'd12:   dout = sr_s;
            5'd13:   dout = cause_s;
            5'd14:   dout = epc_r;
            5'd15:   dout = PRID;
            default: dout = 32'd0;
        endcase
    end

    // State update: reset, exception/interrupt take, otherwise mtc0/eret.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_r      <= 6'd0;
            exl_r     <= 1'b0;
            ie_r      <= 1'b0;
            bd_r      <= 1'b0;
            ip_r      <= 6'd0;
            exccode_r <= 5'd0;
            epc_r     <= 32'd0;
        end else begin
            ip_r <= hwint;
            if (int_req_s) begin
                exl_r     <= 1'b1;
                bd_r      <= bd_m;
                // Interrupts outrank a same-cycle exception and record code 0.
                exccode_r <= int_pend_s ? 5'd0 : exccode_m;
                epc_r     <= exc_epc_s;
            end else begin
                if (wr_sr_s) begin
                    im_r  <= din[15:10];
                    ie_r  <= din[0];
                    // eret is applied after the mtc0 value.
                    exl_r <= exl_clr ? 1'b0 : din[1];
                end else if (exl_clr) begin
                    exl_r <= 1'b0;
                end else begin
                    exl_r <= exl_r;
                end
                if (wr_epc_s) begin
                    epc_r <= din_aligned_s;
                end else begin
                    epc_r <= epc_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed vectors push expectations into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_cp0_unit;

    localparam logic [31:0] PRID_V = 32'h2018_0007;
    localparam int SEL_DOUT = 0;
    localparam int SEL_EPC  = 1;
    localparam int SEL_REQ  = 2;

    logic        clk;
    logic        reset;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc_m;
    logic [4:0]  exccode_m;
    logic        bd_m;
    logic        m_valid;
    logic [5:0]  hwint;
    logic        exl_clr;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        int_req;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb_q[$];
    int   pass_cnt;
    int   total_cnt;

    cp0_unit #(.PRID(PRID_V)) dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din), .we(we),
        .pc_m(pc_m), .exccode_m(exccode_m), .bd_m(bd_m), .m_valid(m_valid),
        .hwint(hwint), .exl_clr(exl_clr), .dout(dout), .epc_out(epc_out),
        .int_req(int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push one expectation for the current cycle
    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        sb_q.push_back(c);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Quiet M stage: no write, no eret, no exception, no valid instruction
    task automatic idle();
        we        = 1'b0;
        exl_clr   = 1'b0;
        exccode_m = 5'd0;
        m_valid   = 1'b0;
        bd_m      = 1'b0;
    endtask

    // Monitor: outputs are combinational, compared mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = sb_q.pop_front();
            if (c.sel == SEL_DOUT) act = dout;
            else if (c.sel == SEL_EPC) act = epc_out;
            else act = {31'd0, int_req};
            total_cnt = total_cnt + 1;
            if (act === c.exp) pass_cnt = pass_cnt + 1;
            else $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b1; a1 = 5'd0; a2 = 5'd0; din = 32'd0; pc_m = 32'd0;
        hwint = 6'd0;
        idle();
        cyc();
        // Request suppressed during reset even with an exception present
        exccode_m = 5'd4;
        expect_val(SEL_REQ, 32'd0, "req_in_reset");
        cyc();
        reset = 1'b0; idle(); a1 = 5'd12;
        expect_val(SEL_DOUT, 32'd0, "sr_after_reset");
        expect_val(SEL_EPC, 32'd0, "epc_after_reset");
        cyc();

        // mtc0 SR, then mfc0 reads
        we = 1'b1; a2 = 5'd12; din = 32'h0000_FC01; a1 = 5'd12;
        expect_val(SEL_DOUT, 32'd0, "sr_no_writethrough");
        cyc();
        idle(); a1 = 5'd12;
        expect_val(SEL_DOUT, 32'h0000_FC01, "sr_readback");
        cyc();
        a1 = 5'd15;
        expect_val(SEL_DOUT, PRID_V, "prid");
        cyc();
        a1 = 5'd9;
        expect_val(SEL_DOUT, 32'd0, "unmapped_read");
        cyc();

        // Interrupt take
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
        cyc();
        idle(); hwint = 6'b000001; m_valid = 1'b1; pc_m = 32'h0000_3010;
        expect_val(SEL_REQ, 32'd1, "int_take");
        expect_val(SEL_EPC, 32'd0, "epc_out_before_int");
        cyc();
        m_valid = 1'b1; a1 = 5'd14;
        expect_val(SEL_REQ, 32'd0, "int_masked_by_exl");
        expect_val(SEL_DOUT, 32'h0000_3010, "epc_after_int");
        cyc();
        a1 = 5'd13;
        expect_val(SEL_DOUT, 32'h0000_0400, "cause_after_int");
        cyc();
        a1 = 5'd12;
        expect_val(SEL_DOUT, 32'h0000_0403, "sr_exl_set");
        cyc();

        // Exception in delay slot with SR = 0
        idle(); hwint = 6'd0; we = 1'b1; a2 = 5'd12; din = 32'd0;
        cyc();
        idle(); exccode_m = 5'd4; bd_m = 1'b1; pc_m = 32'h0000_3024; m_valid = 1'b1;
        expect_val(SEL_REQ, 32'd1, "exc_take_ie0");
        cyc();
        idle(); a1 = 5'd14;
        expect_val(SEL_DOUT, 32'h0000_3020, "epc_bd");
        cyc();
        a1 = 5'd13;
        expect_val(SEL_DOUT, 32'h8000_0010, "cause_bd_exc4");
        cyc();

        // Interrupt beats exception 12
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
        cyc();
        idle(); hwint = 6'b000001; m_valid = 1'b1; exccode_m = 5'd12;
        pc_m = 32'h0000_4000;
        expect_val(SEL_REQ, 32'd1, "int_and_exc");
        cyc();
        idle(); hwint = 6'd0; a1 = 5'd13;
        expect_val(SEL_DOUT, 32'h0000_0400, "cause_int_priority");
        cyc();
        a1 = 5'd14;
        expect_val(SEL_DOUT, 32'h0000_4000, "epc_int_priority");
        cyc();

        // mtc0 EPC discarded by same-cycle exception
        we = 1'b1; a2 = 5'd12; din = 32'd0;
        cyc();
        idle(); we = 1'b1; a2 = 5'd14; din = 32'h0000_5000;
        exccode_m = 5'd10; pc_m = 32'h0000_6008; m_valid = 1'b1;
        expect_val(SEL_REQ, 32'd1, "exc_with_mtc0");
        expect_val(SEL_EPC, 32'h0000_4000, "epc_out_no_fwd_on_take");
        cyc();
        idle(); a1 = 5'd14;
        expect_val(SEL_DOUT, 32'h0000_6008, "epc_mtc0_discarded");
        cyc();

        // eret with mtc0 EPC; pending interrupt then fires
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0403; hwint = 6'b000001;
        cyc();
        idle(); exl_clr = 1'b1; we = 1'b1; a2 = 5'd14; din = 32'h0000_3047;
        m_valid = 1'b1;
        expect_val(SEL_EPC, 32'h0000_3044, "epc_out_fwd");
        expect_val(SEL_REQ, 32'd0, "eret_cycle_masked");
        cyc();
        idle(); m_valid = 1'b1; pc_m = 32'h0000_7000; a1 = 5'd14;
        expect_val(SEL_REQ, 32'd1, "int_after_eret");
        expect_val(SEL_DOUT, 32'h0000_3044, "epc_after_eret");
        cyc();
        idle(); hwint = 6'd0; a1 = 5'd12;
        expect_val(SEL_DOUT, 32'h0000_0403, "sr_exl_again");
        cyc();

        // mtc0 SR with EXL set plus eret: EXL ends cleared
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0003; exl_clr = 1'b1;
        cyc();
        idle(); a1 = 5'd12;
        expect_val(SEL_DOUT, 32'h0000_0001, "mtc0_sr_then_eret");
        cyc();

        // EPC wrap-around
        exccode_m = 5'd8; pc_m = 32'd0; bd_m = 1'b1; m_valid = 1'b1;
        expect_val(SEL_REQ, 32'd1, "exc_pc0");
        cyc();
        idle(); a1 = 5'd14;
        expect_val(SEL_DOUT, 32'hFFFF_FFFC, "epc_wrap");
        cyc();

        // Reset while EXL = 1
        reset = 1'b1; exccode_m = 5'd4; m_valid = 1'b1;
        expect_val(SEL_REQ, 32'd0, "req_in_reset_exl");
        cyc();
        reset = 1'b0; idle(); a1 = 5'd12; we = 1'b1; a2 = 5'd13; din = 32'hFFFF_FFFF;
        expect_val(SEL_DOUT, 32'd0, "sr_reset_exl");
        cyc();
        idle(); a1 = 5'd13;
        expect_val(SEL_DOUT, 32'd0, "cause_reset_and_ro");
        cyc();
        a1 = 5'd14;
        expect_val(SEL_DOUT, 32'd0, "epc_reset");
        cyc();

        @(posedge clk);
        if (sb_q.size() != 0) begin
            total_cnt = total_cnt + 1;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the P7 MIPS pipeline, located in the M stage.
- Consumes the per-instruction exception state delivered by the E/M pipeline register: PC_M, exccode_M, bd_M.
- Also takes 6 external hardware interrupt lines; services mtc0/mfc0/eret.
- Decides each cycle whether the pipeline must divert to the handler, and holds SR/Cause/EPC/PRId state.

Parameters:
- PRID, 32'h2018_0007, constant value returned for register 15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- a1  in  5  mfc0 read register select.
- a2  in  5  mtc0 write register select.
- din  in  32  mtc0 write data (forwarded RT value of the M-stage instruction).
- we  in  1  mtc0 write enable.
- pc_m  in  32  PC of the M-stage instruction.
- exccode_m  in  5  exception code of the M-stage instruction; 0 = none.
- bd_m  in  1  M-stage instruction is in a branch delay slot.
- m_valid  in  1  M stage holds a real instruction (not a bubble).
- hwint  in  6  hardware interrupt lines, level-sensitive.
- exl_clr  in  1  eret in M stage.
- dout  out  32  mfc0 read data.
- epc_out  out  32  EPC for eret target.
- int_req  out  1  take exception/interrupt this cycle (flush pipeline, PC <= 0x4180).

Behaviour:
- Register map (any other a1 reads 0):
  - SR (12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC (14): 32-bit; bits [1:0] always 0.
  - PRId (15): PRID.
- Reset (synchronous): SR, Cause and EPC all 0. int_req is forced 0 while reset is high.
- Combinational request logic:
  - int_pend = |(hwint & SR.IM) & SR.IE & ~SR.EXL & m_valid.
  - exc_pend = (exccode_m != 0) & ~SR.EXL.
  - int_req = int_pend | exc_pend. Same-cycle response, no latency.
- Priority: an interrupt wins over an exception in the same cycle. ExcCode is written as 0 for an interrupt, otherwise exccode_m.
- On a clk edge with int_req = 1:
  - EXL <= 1; Cause.BD <= bd_m; Cause.ExcCode as above.
  - EPC <= bd_m ? {pc_m[31:2],2'b00} - 4 : {pc_m[31:2],2'b00}.
  - A same-cycle mtc0 is discarded.
  - A same-cycle exl_clr is ignored; int_req wins.
- Cause.IP <= hwint every cycle, independent of all other events (including while int_req is high).
- mtc0 (we = 1 and int_req = 0):
  - a2 = 12: writes IM/EXL/IE from din.
  - a2 = 14: EPC <= {din[31:2],2'b00}.
  - a2 = 13 or 15, or any other address: no effect.
- eret (exl_clr = 1, int_req = 0): EXL <= 0 on the edge.
  - If mtc0 to SR occurs in the same cycle, the mtc0 value is written first and then EXL is cleared.
- epc_out forwarding: if we & a2 = 14 & ~int_req, epc_out = {din[31:2],2'b00}; else epc_out = EPC.
- dout: combinational read of current register contents; no write-through forwarding.
- Nesting: while EXL = 1, both interrupts and exceptions are masked and no state changes except via mtc0/eret/IP.
- EPC wrap-around: pc_m = 0 with bd_m = 1 gives EPC = 32'hFFFF_FFFC (modulo-2^32 arithmetic).

Test Plan:
- Reset then mtc0 SR ← 32'h0000_FC01 -> dout(a1 = 12) = 32'h0000_FC01; dout(a1 = 15) = PRID; dout(a1 = 9) = 0.
- SR = 32'h0000_0401, hwint = 6'b000001, m_valid = 1, pc_m = 32'h0000_3010, bd_m = 0:
  - int_req = 1 same cycle.
  - Next cycle: EPC = 32'h0000_3010, ExcCode = 0, EXL = 1, int_req = 0, dout(13)[15:10] = 6'b000001.
- exccode_m = 5'd4, bd_m = 1, pc_m = 32'h0000_3024, SR = 0:
  - int_req = 1 (exceptions are not masked by IE).
  - Next cycle: EPC = 32'h0000_3020, Cause = 32'h8000_0010.
- Simultaneous interrupt and exccode_m = 5'd12 -> ExcCode = 0 recorded.
- Simultaneous mtc0 EPC ← 32'h0000_5000 and exception -> EPC holds the exception PC, not 32'h0000_5000.
- EXL = 1, exl_clr = 1 with we = 1, a2 = 14, din = 32'h0000_3047:
  - epc_out = 32'h0000_3044 same cycle.
  - Next cycle: EXL = 0, EPC = 32'h0000_3044.
  - A pending enabled interrupt now raises int_req.
- Reset asserted while EXL = 1 -> SR, Cause and EPC all 0 next cycle; int_req = 0 during reset.
